addsub_arbiter: RTL and testbench



---
 rtl/addsub_pkg.sv | 21 ++
 rtl/addsub_unit.sv | 27 ++
 rtl/addsub_arbiter.sv | 135 +++++++++++++
 tb/tb_addsub_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and constants for the two-requester add/subtract arbiter.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int DEF_WIDTH = 4;
    localparam int RES_W     = DEF_WIDTH + 2;

    // Result width for an arbitrary operand width: carry bit plus WIDTH+1 sum bits.
    function automatic int res_w(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/addsub_unit.sv
// Combinational add/subtract: {carry, sum} = (a op b) mod 2^(WIDTH+2), operands zero-extended.
// Zero latency, no handshake.
module addsub_unit
    import addsub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic [WIDTH:0]   sum,
    output logic             carry
);

    localparam int RW = res_w(WIDTH);

    logic [RW-1:0] ext_a;
    logic [RW-1:0] ext_b;
    logic [RW-1:0] result;

    assign ext_a  = RW'(a);
    assign ext_b  = RW'(b);
    assign result = (op == OP_SUB) ? (ext_a - ext_b) : (ext_a + ext_b);

    assign {carry, sum} = result;

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin share of one add/sub datapath between two requesters; result valid one edge after EXEC.
// Accepts one op per 3 cycles at best; requesters stall (ready low) until the result handshake completes.
module addsub_arbiter
    import addsub_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_op,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH:0]   res_sum,
    output logic             res_carry,
    output logic             res_id,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    state_t           state;
    state_t           state_nxt;
    logic             last_grant;
    logic             grant_id;
    logic             grant_vld;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             op_q;
    logic             id_q;
    logic [WIDTH:0]   unit_sum;
    logic             unit_carry;

    addsub_unit #(
        .WIDTH (WIDTH)
    ) u_addsub_unit (
        .a     (a_q),
        .b     (b_q),
        .op    (op_q),
        .sum   (unit_sum),
        .carry (unit_carry)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Ready is gated by reset so both requesters see 0 while reset is held.
    always_comb begin
        state_nxt  = state;
        grant_vld  = 1'b0;
        grant_id   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                grant_vld = (req0_valid | req1_valid) & ~reset;
                if (req0_valid && req1_valid) begin
                    grant_id = ~last_grant;
                end else begin
                    grant_id = req1_valid;
                end
                req0_ready = grant_vld & ~grant_id;
                req1_ready = grant_vld & grant_id;
                if (grant_vld) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= 1'b0;
            id_q       <= 1'b0;
            res_valid  <= 1'b0;
            res_sum    <= '0;
            res_carry  <= 1'b0;
            res_id     <= 1'b0;
            ops_done   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        a_q        <= grant_id ? req1_a  : req0_a;
                        b_q        <= grant_id ? req1_b  : req0_b;
                        op_q       <= grant_id ? req1_op : req0_op;
                        id_q       <= grant_id;
                        last_grant <= grant_id;
                    end
                end
                EXEC: begin
                    res_sum   <= unit_sum;
                    res_carry <= unit_carry;
                    res_id    <= id_q;
                    res_valid <= 1'b1;
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (ops_done != {CNT_W{1'b1}}) begin
                            ops_done <= ops_done + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_addsub_arbiter.sv
// Randomized and directed bench for addsub_arbiter against a transaction-level reference model.
module tb_addsub_arbiter;

    localparam int W   = 4;
    localparam int CW  = 8;
    localparam int MOD = 1 << (W + 2);
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic          req0_op, req1_op;
    logic          res_valid, res_ready;
    logic [W:0]    res_sum;
    logic          res_carry, res_id, busy;
    logic [CW-1:0] ops_done;

    always #5 clk = ~clk;

    addsub_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_carry  (res_carry),
        .res_id     (res_id),
        .busy       (busy),
        .ops_done   (ops_done)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: one outstanding operation, its age, and what the result port shows.
    bit m_pend;
    int m_age;
    int m_last;
    int m_ops;
    int m_lat_res, m_lat_id;
    int m_out_res, m_out_id;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    function automatic int arith(input int a, input int b, input int op);
        int r;
        r = (op != 0) ? (a - b) : (a + b);
        return ((r % MOD) + MOD) % MOD;
    endfunction

    task automatic model_reset();
        m_pend    = 1'b0;
        m_age     = 0;
        m_last    = 1;
        m_ops     = 0;
        m_out_res = 0;
        m_out_id  = 0;
    endtask

    task automatic cycle(input logic v0, input int a0, input int b0, input logic o0,
                         input logic v1, input int a1, input int b1, input logic o1,
                         input logic rr);
        int g;
        @(negedge clk);
        req0_valid = v0; req0_a = W'(a0); req0_b = W'(b0); req0_op = o0;
        req1_valid = v1; req1_a = W'(a1); req1_b = W'(b1); req1_op = o1;
        res_ready  = rr;
        #1;
        g = -1;
        if (!m_pend) begin
            if (v0 && v1) g = (m_last == 0) ? 1 : 0;
            else if (v0)  g = 0;
            else if (v1)  g = 1;
        end
        chk("req0_ready", 32'(req0_ready), 32'(g == 0));
        chk("req1_ready", 32'(req1_ready), 32'(g == 1));
        chk("busy",       32'(busy),       32'(m_pend));
        chk("res_valid",  32'(res_valid),  32'(m_pend && m_age >= 1));
        chk("res_sum",    32'(res_sum),    32'(m_out_res % 32));
        chk("res_carry",  32'(res_carry),  32'(m_out_res / 32));
        chk("res_id",     32'(res_id),     32'(m_out_id));
        chk("ops_done",   32'(ops_done),   32'(m_ops));
        if (!m_pend) begin
            if (g >= 0) begin
                m_pend    = 1'b1;
                m_age     = 0;
                m_lat_res = (g == 1) ? arith(a1, b1, int'(o1)) : arith(a0, b0, int'(o0));
                m_lat_id  = g;
                m_last    = g;
            end
        end else if (m_age == 0) begin
            m_age     = 1;
            m_out_res = m_lat_res;
            m_out_id  = m_lat_id;
        end else if (rr) begin
            m_pend = 1'b0;
            if (m_ops < SAT) m_ops++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        chk("pre_rst_busy", 32'(busy), 32'(m_pend));
        reset      = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_busy",      32'(busy),      0);
        chk("rst_ops_done",  32'(ops_done),  0);
        chk("rst_res_sum",   32'(res_sum),   0);
        chk("rst_ready",     32'({req0_ready, req1_ready}), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic rnd_cycle(input int rr_bias);
        cycle($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1),
              $urandom_range(0, 99) < rr_bias);
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        res_ready = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("init_res_valid", 32'(res_valid), 0);
        chk("init_busy",      32'(busy),      0);
        chk("init_ready",     32'({req0_ready, req1_ready}), 0);
        chk("init_sum_carry", 32'({res_carry, res_sum}), 0);
        chk("init_ops_done",  32'(ops_done),  0);
        @(negedge clk);
        reset = 1'b0;

        // single add 9+6, then subtract underflow 3-5, then 0-0
        cycle(1, 9, 6, 0, 0, 0, 0, 0, 1);
        idle(3);
        cycle(0, 0, 0, 0, 1, 3, 5, 1, 1);
        idle(3);
        cycle(1, 0, 0, 1, 0, 0, 0, 0, 1);
        idle(3);

        // both requesters continuously valid: grants must alternate
        for (int i = 0; i < 12; i++) cycle(1, 15, 15, 0, 1, 7, 2, 1, 1);
        idle(2);

        // result backpressure, with the other requester waiting
        cycle(1, 4, 9, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 1, 1, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 1, 1, 0, 1);
        idle(4);

        // reset while in EXEC, then a tie must go to requester 0
        cycle(1, 2, 3, 0, 1, 5, 1, 1, 1);
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1, 1, 2, 0, 1, 6, 6, 1, 1);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            rnd_cycle(70);
        end

        // sustained traffic pushes the counter into saturation
        for (int i = 0; i < 900; i++) rnd_cycle(100);
        idle(3);
        chk("ops_saturated", 32'(ops_done), SAT);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
